// File: rtl/bus_arbiter4_if.sv
// Bus bundle between the four producers, the round-robin arbiter and the
// downstream consumer of the muxed output.
interface bus_arbiter4_if #(parameter int width = 16);
  logic [3:0]       req;
  logic [width-1:0] in0, in1, in2, in3;
  logic [3:0]       gnt;
  logic [1:0]       sel;
  logic [width-1:0] out;
  logic             out_valid;

  modport master (output req, in0, in1, in2, in3,
                  input  gnt, sel, out, out_valid);
  modport slave  (input  req, in0, in1, in2, in3,
                  output gnt, sel, out, out_valid);
endinterface

// File: rtl/bus_arbiter4.sv
// Four-source round-robin arbiter with bounded bursts; owns the mux select and
// registers the granted source's data onto the shared bus.
module bus_arbiter4 #(
  parameter int width     = 16,
  parameter int MAX_BURST = 4
) (
  input logic           clk,
  input logic           reset_n,
  bus_arbiter4_if.slave bus
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BUSY  = 1'b1;
  localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

  logic [0:0]            state;
  logic [3:0]            gnt_r;
  logic [1:0]            sel_r;
  logic [1:0]            last;
  logic [3:0]            count;
  logic [width-1:0]      out_r;
  logic                  vld_r;
  logic [3:0][width-1:0] src;
  logic [1:0]            win;
  logic                  xfer;
  logic                  rel;

  assign src = {bus.in3, bus.in2, bus.in1, bus.in0};

  // Search from last+1 upward; k=4 lands on last itself, so the source just
  // released (or last served) always has the lowest priority.
  always_comb begin
    win = last;
    for (int k = 4; k >= 1; k--) begin
      if (bus.req[2'(last + 2'(k))]) win = 2'(last + 2'(k));
    end
  end

  // In BUSY, sel is the granted index, so gnt[sel] & req[sel] is a transfer.
  assign xfer = (state == ST_BUSY) && bus.req[sel_r];
  assign rel  = (state == ST_BUSY) && (!bus.req[sel_r] || (xfer && count == LAST_CNT));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      gnt_r <= '0;
      sel_r <= '0;
      last  <= 2'd3;
      count <= '0;
      out_r <= '0;
      vld_r <= 1'b0;
    end else begin
      vld_r <= xfer;
      if (xfer) begin
        out_r <= src[sel_r];
        count <= count + 4'd1;
      end
      if (state == ST_IDLE || rel) begin
        if (|bus.req) begin
          state <= ST_BUSY;
          gnt_r <= 4'b0001 << win;
          sel_r <= win;
          last  <= win;
          count <= '0;
        end else if (rel) begin
          state <= ST_IDLE;
          gnt_r <= '0;
          count <= '0;
        end
      end
    end
  end

  assign bus.gnt       = gnt_r;
  assign bus.sel       = sel_r;
  assign bus.out       = out_r;
  assign bus.out_valid = vld_r;
endmodule
